// File: rtl/carbon_uart_pkg.sv
// Shared types and constants for the carbon UART transmitter.
package carbon_uart_pkg;

  localparam int unsigned CARBON_UART_DATA_BITS = 8;
  localparam int unsigned CARBON_UART_IDX_W     = $clog2(CARBON_UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/carbon_uart_fifo.sv
// Synchronous byte FIFO with registered level/full/empty; pushes while full and pops while empty are ignored.
module carbon_uart_fifo
  import carbon_uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned WIDTH   = CARBON_UART_DATA_BITS,
  localparam int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;
  logic [LEVEL_W-1:0] level_n;

  // Full is judged on the registered state, so a same-cycle pop cannot make room.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_n = level;
    if (push_ok && !pop_ok) begin
      level_n = level + LEVEL_W'(1);
    end else if (!push_ok && pop_ok) begin
      level_n = level - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_n;
      full  <= (level_n == LEVEL_W'(DEPTH));
      empty <= (level_n == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/carbon_uart_tx.sv
// Console UART transmitter: buffers MMIO byte strobes and sends them as 8N1/8N2 frames on txd.
module carbon_uart_tx
  import carbon_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1,
  localparam int unsigned LEVEL_W   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tx_valid,
  input  logic [CARBON_UART_DATA_BITS-1:0] tx_byte,
  input  logic                             ovf_clr,
  output logic                             txd,
  output logic                             busy,
  output logic [LEVEL_W-1:0]               fifo_level,
  output logic                             fifo_full,
  output logic                             overflow
);

  localparam int unsigned STOP_LEN = STOP_BITS * CLK_DIV;
  localparam int unsigned CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int unsigned IDX_W    = CARBON_UART_IDX_W;

  uart_tx_state_e                   state_q, state_n;
  logic [CNT_W-1:0]                 bit_cnt_q, bit_cnt_n;
  logic [IDX_W-1:0]                 bit_idx_q, bit_idx_n;
  logic [CARBON_UART_DATA_BITS-1:0] shift_q, shift_n;
  logic [CARBON_UART_DATA_BITS-1:0] fifo_head;
  logic                             fifo_empty;
  logic                             pop_c;
  logic                             txd_c;
  logic                             drop_c;

  carbon_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CARBON_UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_valid),
    .wr_data (tx_byte),
    .pop     (pop_c),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign drop_c = tx_valid && fifo_full;

  // Next-state and line level; a new frame chains straight out of STOP when data is waiting.
  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    bit_idx_n = bit_idx_q;
    shift_n   = shift_q;
    pop_c     = 1'b0;
    txd_c     = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          shift_n   = fifo_head;
          bit_cnt_n = CNT_W'(CLK_DIV - 1);
          state_n   = START;
        end
      end
      START: begin
        txd_c = 1'b0;
        if (bit_cnt_q == '0) begin
          bit_idx_n = '0;
          bit_cnt_n = CNT_W'(CLK_DIV - 1);
          state_n   = DATA;
        end else begin
          bit_cnt_n = bit_cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        txd_c = shift_q[0];
        if (bit_cnt_q == '0) begin
          shift_n = shift_q >> 1;
          if (bit_idx_q == IDX_W'(CARBON_UART_DATA_BITS - 1)) begin
            bit_cnt_n = CNT_W'(STOP_LEN - 1);
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx_q + IDX_W'(1);
            bit_cnt_n = CNT_W'(CLK_DIV - 1);
          end
        end else begin
          bit_cnt_n = bit_cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        txd_c = 1'b1;
        if (bit_cnt_q == '0) begin
          if (!fifo_empty) begin
            pop_c     = 1'b1;
            shift_n   = fifo_head;
            bit_cnt_n = CNT_W'(CLK_DIV - 1);
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt_q - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // txd and busy follow the current state by one cycle so the pin is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      bit_idx_q <= bit_idx_n;
      shift_q   <= shift_n;
      txd       <= txd_c;
      busy      <= (state_q != IDLE) || !fifo_empty;
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
